// File: rtl/count_tick_gen.sv
// count_tick_gen: programmable tick pulse generator (continuous or burst of N ticks)
// feeding the enable input of a downstream counter.
module count_tick_gen #(
    parameter int DIV_W   = 8,
    parameter int LEN_W   = 4,
    parameter int DEF_DIV = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ready,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [LEN_W-1:0] burst_len,
    output logic             tick,
    output logic             busy,
    output logic             done
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t           state;
    logic [DIV_W-1:0] div_reg;
    logic [DIV_W-1:0] pre_cnt;
    logic [LEN_W-1:0] rem;
    logic             burst;
    assign cfg_ready = state == IDLE;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            div_reg <= DIV_W'(DEF_DIV);
            pre_cnt <= '0;
            rem     <= '0;
            burst   <= 1'b0;
            tick    <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            tick <= 1'b0;
            done <= 1'b0;
            if (state == IDLE) begin
                if (cfg_valid)
                    div_reg <= cfg_div;
                if (start && !stop) begin
                    if (mode && burst_len == '0) begin
                        done <= 1'b1;
                    end else begin
                        state   <= RUN;
                        busy    <= 1'b1;
                        burst   <= mode;
                        rem     <= burst_len;
                        pre_cnt <= '0;
                    end
                end
            end else if (stop) begin
                // abort takes priority over a tick falling due on the same edge
                state   <= IDLE;
                busy    <= 1'b0;
                pre_cnt <= '0;
            end else if (pre_cnt == div_reg) begin
                pre_cnt <= '0;
                tick    <= 1'b1;
                if (burst) begin
                    rem <= rem - LEN_W'(1);
                    if (rem == LEN_W'(1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
            end else begin
                pre_cnt <= pre_cnt + DIV_W'(1);
            end
        end
    end
endmodule
